dm_axi_master: RTL and testbench
================================

# dm_axi_master

Data-memory access engine sitting directly downstream of the MEM pipeline stage. It accepts the MEM stage's load/store request (address, byte-write-enable mask, store data) and runs one single-beat AXI4 transaction on the CPU's data master port. While the transaction is in flight it holds the pipeline with `AXI_stall`. For loads it returns `DM_DO` together with the `rvalid_out1` capture strobe that the MEM stage uses to latch load data.

## Interface
- `ID_W`, 4: AXI ID width.
- `M_ID`, 4'd1: constant ARID/AWID value for this master.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `MEM_read_M`  in  1  load request from the MEM stage, held until `AXI_stall` drops.
- `MEM_write_M`  in  1  store request, held the same way.
- `ALU_result_M`  in  32  byte address.
- `DM_BWEB`  in  32  active-low bit write mask from the MEM stage.
- `DM_DI`  in  32  store data, already lane-aligned.
- `DM_DO`  out  32  load data returned to the MEM stage.
- `rvalid_out1`  out  1  one-cycle strobe: `DM_DO` is valid this cycle.
- `AXI_stall`  out  1  pipeline hold.
- `dm_err`  out  1  sticky bus-error flag (see Configuration).
- AR channel: `ARID`[ID_W], `ARADDR`[32], `ARLEN`[4], `ARSIZE`[3], `ARBURST`[2], `ARVALID` out; `ARREADY` in.
- R channel: `RID`, `RDATA`[32], `RRESP`[2], `RLAST`, `RVALID` in; `RREADY` out.
- AW channel: same fields as AR, prefixed AW.
- W channel: `WDATA`[32], `WSTRB`[4], `WLAST`, `WVALID` out; `WREADY` in.
- B channel: `BID`, `BRESP`[2], `BVALID` in; `BREADY` out.

## Operation
- FSM states:
  - IDLE
  - AR: ARVALID=1.
  - R: RREADY=1.
  - WR: AWVALID and/or WVALID.
  - B: BREADY=1.
  - DONE
- IDLE:
  - If `MEM_read_M`, latch the address and go to AR.
  - Else if `MEM_write_M`, latch address, `DM_DI` and strobes, clear the aw_done/w_done flags, and go to WR.
  - If both requests are asserted, which is illegal, the read is serviced and the write is ignored.
- Latched request fields drive the AXI signals. They stay stable while VALID is high regardless of input changes.
- Fixed AXI fields:
  - `ARADDR`/`AWADDR` = {addr[31:2],2'b00}.
  - LEN=0, SIZE=3'b010, BURST=2'b01.
  - `WLAST`=1.
  - ID=`M_ID`.
- `WSTRB[i]` = ~&DM_BWEB[8i+7:8i]; a byte is written if any of its bits is enabled.
- AR: on ARVALID&ARREADY, go to R.
- R: on RVALID&RLAST, capture RDATA into `rdata_q`, pulse `rvalid_out1`, and go to DONE. RID is not checked.
- WR:
  - `AWVALID` = !aw_done; `WVALID` = !w_done.
  - Each handshake sets its done flag; same-cycle handshakes on both channels are allowed.
  - Go to B in the cycle both handshakes are complete.
- B: on BVALID, go to DONE.
- DONE: lasts one cycle, then IDLE.
- `AXI_stall` = (IDLE & (MEM_read_M|MEM_write_M)) | (state ∉ {IDLE, DONE}). It is combinational, so it is low in DONE and the pipeline advances at the end of that cycle. The next request is seen in IDLE the following cycle.
- `DM_DO` = (state==R & RVALID) ? RDATA : rdata_q. Data is valid in the same cycle as `rvalid_out1`.

## Timing
- Reset values:
  - FSM in IDLE.
  - All VALID/READY outputs 0.
  - `rdata_q` = 0, so `DM_DO` = 0.
  - `rvalid_out1` = 0, `dm_err` = 0.
  - `AXI_stall` = 0 while no request is present.
- Best-case load, with ARREADY=1 and RVALID one cycle later:
  - c0: IDLE, stall=1.
  - c1: AR handshake.
  - c2: R, `rvalid_out1`=1.
  - c3: DONE, stall=0.
  - Total: 3 stall cycles.
- Best-case store, with AWREADY=WREADY=1:
  - c1: WR handshake.
  - c2: B.
  - c3: DONE.
  - Total: 3 stall cycles.
- Every slave wait cycle adds exactly one stall cycle.
- `rvalid_out1` is high for exactly one cycle per load and never during stores.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously. There is no completion or recovery of the outstanding transfer.

## Configuration
- `DM_AXI_RESP_CHECK_EN` defined:
  - `dm_err` is set when RRESP≠2'b00 at the R handshake or BRESP≠2'b00 at the B handshake.
  - It stays set until `rst`.
  - The transaction still completes normally.
- `DM_AXI_RESP_CHECK_EN` undefined: `dm_err` is tied to 0 and RRESP/BRESP are ignored.

## Test plan
- Load at 0x0000_1006, ARREADY=1, RVALID next cycle with RDATA=0xDEADBEEF -> ARADDR=0x0000_1004; `rvalid_out1` and `DM_DO`=0xDEADBEEF in the same cycle; 3 stall cycles; `DM_DO` then holds 0xDEADBEEF.
- Store with DM_BWEB=0xFFFF00FF and DM_DI=0x00AB0000, AWREADY delayed 2 cycles and WREADY=1 -> WSTRB=4'b0010; WVALID drops after 1 cycle while AWVALID is held; B reached once both handshakes are done; 5 stall cycles.
- Back-to-back load then store with the request inputs changing after DONE -> a second transaction starts from IDLE with no dropped or duplicated transfer, and ARADDR stays stable while ARVALID is high.
- BRESP=2'b10 on a store -> `dm_err`=1 with the macro defined and 0 without it; the store still completes and the flag persists until reset.
- `rst` asserted while in R with RVALID low -> RREADY=0, `AXI_stall`=0 (no request), FSM in IDLE; the next load proceeds normally.
- MEM_read_M and MEM_write_M both asserted -> only the AR channel is used; AWVALID and WVALID stay 0.

Source files
------------

// File: rtl/dm_axi_if.sv
// Single-beat AXI4 bus bundle between the data-memory engine and its slave.
interface dm_axi_if #(
  parameter int ID_W = 4
) ();
  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [3:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;

  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [3:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;

  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;

  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/dm_axi_master.sv
// Data-memory AXI4 single-beat master: turns MEM-stage load/store requests into AXI transfers.
// Optional bus-error reporting is enabled with `define DM_AXI_RESP_CHECK_EN.
module dm_axi_master #(
  parameter int              ID_W = 4,
  parameter logic [ID_W-1:0] M_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MEM_read_M,
  input  logic         MEM_write_M,
  input  logic [31:0]  ALU_result_M,
  input  logic [31:0]  DM_BWEB,
  input  logic [31:0]  DM_DI,
  output logic [31:0]  DM_DO,
  output logic         rvalid_out1,
  output logic         AXI_stall,
  output logic         dm_err,
  dm_axi_if.master     axi
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [29:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic [31:0] rdata_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic        aw_hs_s;
  logic        w_hs_s;
  logic        r_fin_s;

  // A byte lane is written when any bit of its active-low mask is enabled.
  function automatic logic [3:0] bweb_to_strb(input logic [31:0] bweb);
    logic [3:0] strb;
    for (int i = 0; i < 4; i++) begin
      strb[i] = ~&bweb[8*i +: 8];
    end
    return strb;
  endfunction

  assign aw_hs_s = (state_r == ST_WR) && !aw_done_r && axi.AWREADY;
  assign w_hs_s  = (state_r == ST_WR) && !w_done_r && axi.WREADY;
  assign r_fin_s = (state_r == ST_R) && axi.RVALID && axi.RLAST;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a simultaneous read and write request services the read only.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (MEM_read_M) begin
          state_s = ST_AR;
        end else if (MEM_write_M) begin
          state_s = ST_WR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (axi.ARREADY) begin
          state_s = ST_R;
        end else begin
          state_s = ST_AR;
        end
      end
      ST_R: begin
        if (r_fin_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_R;
        end
      end
      ST_WR: begin
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_s = ST_B;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_B: begin
        if (axi.BVALID) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_B;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request capture, per-channel write progress and load data holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r    <= 30'd0;
      wdata_r   <= 32'd0;
      wstrb_r   <= 4'd0;
      rdata_r   <= 32'd0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      if (state_r == ST_IDLE) begin
        if (MEM_read_M) begin
          addr_r <= ALU_result_M[31:2];
        end else if (MEM_write_M) begin
          addr_r    <= ALU_result_M[31:2];
          wdata_r   <= DM_DI;
          wstrb_r   <= bweb_to_strb(DM_BWEB);
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
      end
      if (aw_hs_s) begin
        aw_done_r <= 1'b1;
      end
      if (w_hs_s) begin
        w_done_r <= 1'b1;
      end
      if (r_fin_s) begin
        rdata_r <= axi.RDATA;
      end
    end
  end

  assign axi.ARID    = M_ID;
  assign axi.ARADDR  = {addr_r, 2'b00};
  assign axi.ARLEN   = 4'd0;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = (state_r == ST_AR);
  assign axi.RREADY  = (state_r == ST_R);

  assign axi.AWID    = M_ID;
  assign axi.AWADDR  = {addr_r, 2'b00};
  assign axi.AWLEN   = 4'd0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = (state_r == ST_WR) && !aw_done_r;

  assign axi.WDATA   = wdata_r;
  assign axi.WSTRB   = wstrb_r;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = (state_r == ST_WR) && !w_done_r;
  assign axi.BREADY  = (state_r == ST_B);

  // Stall is combinational so the pipeline advances at the end of DONE.
  assign AXI_stall   = ((state_r == ST_IDLE) && (MEM_read_M || MEM_write_M)) ||
                       ((state_r != ST_IDLE) && (state_r != ST_DONE));
  assign rvalid_out1 = r_fin_s;
  assign DM_DO       = ((state_r == ST_R) && axi.RVALID) ? axi.RDATA : rdata_r;

`ifdef DM_AXI_RESP_CHECK_EN
  logic dm_err_r;

  // Sticky error flag; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_err_r <= 1'b0;
    end else if ((r_fin_s && (axi.RRESP != 2'b00)) ||
                 ((state_r == ST_B) && axi.BVALID && (axi.BRESP != 2'b00))) begin
      dm_err_r <= 1'b1;
    end
  end

  assign dm_err = dm_err_r;
  wire unused_ok_s = &{1'b0, axi.RID, axi.BID, ALU_result_M[1:0]};
`else
  assign dm_err = 1'b0;
  wire unused_ok_s = &{1'b0, axi.RID, axi.BID, axi.RRESP, axi.BRESP, ALU_result_M[1:0]};
`endif

endmodule

// File: tb/tb_dm_axi_master.sv
// Bench for dm_axi_master: directed table, randomized transactions against a
// transaction-level model, plus hand-written reset and sticky-error sequences.
module tb_dm_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_read_M, MEM_write_M;
  logic [31:0] ALU_result_M, DM_BWEB, DM_DI, DM_DO;
  logic        rvalid_out1, AXI_stall, dm_err;

  dm_axi_if #(.ID_W(4)) axi ();

  dm_axi_master #(.ID_W(4), .M_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .MEM_read_M(MEM_read_M), .MEM_write_M(MEM_write_M),
    .ALU_result_M(ALU_result_M), .DM_BWEB(DM_BWEB), .DM_DI(DM_DI),
    .DM_DO(DM_DO), .rvalid_out1(rvalid_out1), .AXI_stall(AXI_stall),
    .dm_err(dm_err), .axi(axi)
  );

  always #5 clk = ~clk;

`ifdef DM_AXI_RESP_CHECK_EN
  localparam bit RESP_EN = 1'b1;
`else
  localparam bit RESP_EN = 1'b0;
`endif

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] bweb;
    logic [31:0] di;
    logic [31:0] rdata;
    int          ar_d, r_d, aw_d, w_d, b_d;
    logic [1:0]  resp;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    int          exp_stall;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  bit          err_exp = 1'b0;
  logic [31:0] last_rdata = 32'd0;
  vec_t        dir_tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level expectations from the bus rules.
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    int wmax;
    o.exp_addr = v.addr & ~32'h3;
    o.exp_strb = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (((v.bweb >> (8 * i)) & 32'hFF) != 32'hFF) o.exp_strb[i] = 1'b1;
    end
    wmax = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    o.exp_stall = v.rd ? (3 + v.ar_d + v.r_d) : (3 + wmax + v.b_d);
    return o;
  endfunction

  // Called just after a rising edge; plays slave and checks the whole transaction.
  task automatic run_txn(input vec_t v);
    bit is_rd = v.rd;
    bit is_wr = !v.rd && v.wr;
    int stall_n = 0, rv_n = 0, ar_n = 0, aw_n = 0, w_n = 0, awv_n = 0, wv_n = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit addr_bad = 1'b0, fix_bad = 1'b0, wbad = 1'b0, done = 1'b0;
    logic [31:0] do_at_rv = 32'd0;
    MEM_read_M = v.rd; MEM_write_M = v.wr;
    ALU_result_M = v.addr; DM_BWEB = v.bweb; DM_DI = v.di;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      axi.ARREADY = axi.ARVALID && (ar_cnt == v.ar_d);
      axi.RVALID  = axi.RREADY && (r_cnt == v.r_d);
      axi.RLAST   = axi.RVALID;
      axi.RDATA   = axi.RVALID ? v.rdata : $urandom;
      axi.RRESP   = axi.RVALID ? v.resp : 2'b00;
      axi.AWREADY = axi.AWVALID && (aw_cnt == v.aw_d);
      axi.WREADY  = axi.WVALID && (w_cnt == v.w_d);
      axi.BVALID  = axi.BREADY && (b_cnt == v.b_d);
      axi.BRESP   = axi.BVALID ? v.resp : 2'b00;
      #1;
      if (AXI_stall) stall_n++;
      else done = 1'b1;
      if (rvalid_out1) begin
        rv_n++;
        do_at_rv = DM_DO;
      end
      if (axi.ARVALID) begin
        if (axi.ARADDR !== v.exp_addr) addr_bad = 1'b1;
        if (axi.ARLEN !== 4'd0 || axi.ARSIZE !== 3'b010 || axi.ARBURST !== 2'b01 ||
            axi.ARID !== 4'd1) fix_bad = 1'b1;
        if (axi.ARREADY) ar_n++;
        else ar_cnt++;
      end
      if (axi.RREADY) r_cnt++;
      if (axi.AWVALID) begin
        awv_n++;
        if (axi.AWADDR !== v.exp_addr) addr_bad = 1'b1;
        if (axi.AWLEN !== 4'd0 || axi.AWSIZE !== 3'b010 || axi.AWBURST !== 2'b01 ||
            axi.AWID !== 4'd1) fix_bad = 1'b1;
        if (axi.AWREADY) aw_n++;
        else aw_cnt++;
      end
      if (axi.WVALID) begin
        wv_n++;
        if (axi.WSTRB !== v.exp_strb || axi.WDATA !== v.di || axi.WLAST !== 1'b1) wbad = 1'b1;
        if (axi.WREADY) w_n++;
        else w_cnt++;
      end
      if (axi.BREADY) b_cnt++;
      if (cyc >= 1 && !done) begin
        ALU_result_M = $urandom; DM_BWEB = $urandom; DM_DI = $urandom;
      end
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: stall still high after 200 cycles, expected %0d", v.exp_stall);
    end
    @(posedge clk); #1;
    MEM_read_M = 1'b0; MEM_write_M = 1'b0;
    if (is_rd) last_rdata = v.rdata;
    if (RESP_EN && v.resp != 2'b00) err_exp = 1'b1;
    check("stall_cycles", stall_n, v.exp_stall);
    check("rvalid_pulses", rv_n, is_rd ? 1 : 0);
    if (is_rd) check("dm_do_at_rvalid", do_at_rv, v.rdata);
    check("dm_do_hold", DM_DO, last_rdata);
    check("ar_handshakes", ar_n, is_rd ? 1 : 0);
    check("aw_handshakes", aw_n, is_wr ? 1 : 0);
    check("w_handshakes", w_n, is_wr ? 1 : 0);
    check("awvalid_cycles", awv_n, is_wr ? v.aw_d + 1 : 0);
    check("wvalid_cycles", wv_n, is_wr ? v.w_d + 1 : 0);
    check("addr_stable", addr_bad, 1'b0);
    check("fixed_fields", fix_bad, 1'b0);
    check("wdata_wstrb", wbad, 1'b0);
    check("dm_err", dm_err, err_exp);
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] bweb, input logic [31:0] di,
                              input logic [31:0] rdata, input int ar_d, input int r_d,
                              input int aw_d, input int w_d, input int b_d,
                              input logic [1:0] resp, input logic [31:0] ea,
                              input logic [3:0] es, input int est);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.bweb = bweb; v.di = di; v.rdata = rdata;
    v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.resp = resp;
    v.exp_addr = ea; v.exp_strb = es; v.exp_stall = est;
    return v;
  endfunction

  initial begin
    // rd wr addr bweb di rdata ar r aw w b resp | exp addr, strb, stall
    dir_tbl[0] = mk(1'b1, 1'b0, 32'h0000_1006, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF,
                    0, 0, 0, 0, 0, 2'b00, 32'h0000_1004, 4'b0000, 3);
    dir_tbl[1] = mk(1'b0, 1'b1, 32'h0000_2001, 32'hFFFF_00FF, 32'h00AB_0000, 32'h0,
                    0, 0, 2, 0, 0, 2'b00, 32'h0000_2000, 4'b0010, 5);
    dir_tbl[2] = mk(1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 32'hCAFE_F00D,
                    1, 0, 0, 0, 0, 2'b00, 32'h0000_3000, 4'b0000, 4);
    dir_tbl[3] = mk(1'b0, 1'b1, 32'h0000_3008, 32'h0000_0000, 32'h1122_3344, 32'h0,
                    0, 0, 0, 0, 0, 2'b00, 32'h0000_3008, 4'b1111, 3);
    dir_tbl[4] = mk(1'b0, 1'b1, 32'h0000_0043, 32'h00FF_FFFF, 32'h5500_0000, 32'h0,
                    0, 0, 0, 3, 1, 2'b10, 32'h0000_0040, 4'b1000, 7);
    dir_tbl[5] = mk(1'b1, 1'b1, 32'h0000_0050, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678,
                    0, 2, 0, 0, 0, 2'b00, 32'h0000_0050, 4'b0000, 5);

    rst = 1'b1;
    MEM_read_M = 1'b0; MEM_write_M = 1'b0;
    ALU_result_M = 32'd0; DM_BWEB = 32'hFFFF_FFFF; DM_DI = 32'd0;
    axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RLAST = 1'b0; axi.RDATA = 32'd0;
    axi.RRESP = 2'b00; axi.RID = 4'd1; axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    axi.BVALID = 1'b0; axi.BRESP = 2'b00; axi.BID = 4'd1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valids", {axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID, axi.BREADY}, 5'b0);
    check("reset_dm_do", DM_DO, 32'd0);
    check("reset_flags", {rvalid_out1, AXI_stall, dm_err}, 3'b000);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_txn(dir_tbl[i]);

    for (int i = 0; i < 30; i++) begin
      vec_t v;
      v.rd = $urandom_range(0, 1);
      v.wr = v.rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      v.addr = $urandom; v.bweb = $urandom; v.di = $urandom; v.rdata = $urandom;
      if ($urandom_range(0, 1) == 1) v.bweb = {{8{v.bweb[31]}}, {8{v.bweb[23]}}, {8{v.bweb[15]}}, {8{v.bweb[7]}}};
      v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
      v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
      v.resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v = model(v);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        check("idle_no_stall", AXI_stall, 1'b0);
      end
      run_txn(v);
    end

    // Reset while waiting for read data.
    MEM_read_M = 1'b1; ALU_result_M = 32'h0000_0070;
    @(negedge clk);
    @(negedge clk);
    check("rst_seq_arvalid", axi.ARVALID, 1'b1);
    axi.ARREADY = 1'b1;
    @(negedge clk);
    axi.ARREADY = 1'b0;
    check("rst_seq_rready", axi.RREADY, 1'b1);
    #1 rst = 1'b1; MEM_read_M = 1'b0;
    #1;
    check("rst_mid_rready", axi.RREADY, 1'b0);
    check("rst_mid_stall", AXI_stall, 1'b0);
    check("rst_mid_dm_do", DM_DO, 32'd0);
    check("rst_mid_err", dm_err, 1'b0);
    err_exp = 1'b0; last_rdata = 32'd0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_txn(model(mk(1'b1, 1'b0, 32'h0000_0074, 32'h0, 32'h0, 32'hA5A5_5A5A,
                     0, 1, 0, 0, 0, 2'b00, 32'h0, 4'h0, 0)));

    // Sticky error: faulty store, then a clean load keeps the flag.
    run_txn(model(mk(1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FF00, 32'h0000_00EE, 32'h0,
                     0, 0, 1, 1, 0, 2'b10, 32'h0, 4'h0, 0)));
    run_txn(model(mk(1'b1, 1'b0, 32'h0000_0104, 32'h0, 32'h0, 32'h0BAD_F00D,
                     0, 0, 0, 0, 0, 2'b00, 32'h0, 4'h0, 0)));
    rst = 1'b1; #1;
    check("err_cleared_by_rst", dm_err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
